// File: rtl/memory_sequencer_if.sv
// Board-side bundle for the memory game sequencer.
//   go     : level request to start the next round
//   btn    : one-cycle, debounced button pulses (one bit per channel)
//   led    : playback lights, one-hot or zero
//   level  : current sequence length
//   busy   : high whenever the sequencer is not idle
//   pass   : one-cycle pulse on a correctly answered round
//   fail   : one-cycle pulse on a wrong/multi-hot press or a timeout
//   win    : sticky, set after passing the longest round
// The master modport is the board/test side and the slave modport is the sequencer.
interface memory_sequencer_if #(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic              go;
    logic [NUM_CH-1:0] btn;
    logic [NUM_CH-1:0] led;
    logic [LW-1:0]     level;
    logic              busy;
    logic              pass;
    logic              fail;
    logic              win;

    modport master (
        output go, btn,
        input  led, level, busy, pass, fail, win
    );

    modport slave (
        input  go, btn,
        output led, level, busy, pass, fail, win
    );
endinterface

// File: rtl/memory_sequencer.sv
// Challenge/response engine for the memory game. Each round appends one
// pseudo-random element to the stored sequence, plays the whole sequence
// back on the lights, then checks the player's presses against it.
// Ports:
//   clk    : system clock
//   resetn : synchronous, active-low reset
//   bus    : memory_sequencer_if slave (go/btn in; led/level/busy/pass/fail/win out)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for go; a pending win is cleared when go arrives
// S_APPEND | store new element at seq[level], grow level, rewind idx
// S_SHOW_ON| light seq[idx] for STEP_CYCLES cycles
// S_SHOW_OFF| lights off for STEP_CYCLES cycles, then next element or input
// S_WAIT_IN| compare presses with seq[idx], timeout between presses
// S_PASS   | one-cycle pass pulse, set win on the longest round
// S_FAIL   | one-cycle fail pulse, sequence length back to zero
module memory_sequencer #(
    parameter int          NUM_CH         = 4,
    parameter int          MAX_LEN        = 16,
    parameter int          STEP_CYCLES    = 25000000,
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input logic              clk,
    input logic              resetn,
    memory_sequencer_if.slave bus
);
    localparam int CW      = $clog2(NUM_CH);
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_MAX = (STEP_CYCLES > TIMEOUT_CYCLES) ? STEP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX);

    localparam logic [CNTW-1:0] STEP_LOAD = CNTW'(STEP_CYCLES - 1);
    localparam logic [CNTW-1:0] TO_LOAD   = (TIMEOUT_CYCLES > 0) ? CNTW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_IN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     level_q, level_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [CNTW-1:0]   cnt_q,   cnt_d;
    logic              win_q,   win_d;
    logic [15:0]       lfsr_q,  lfsr_d;

    // Sequence store is deliberately left out of reset.
    logic [CW-1:0]     seq_q [MAX_LEN];
    logic              seq_we;

    logic [CW-1:0]     v_raw;
    logic [CW:0]       v_ext;
    logic [CW-1:0]     v_new;
    logic [CW-1:0]     cur_sym;
    logic [NUM_CH-1:0] cur_onehot;
    logic              last_elem;
    logic              press;

    // Fold out-of-range LFSR values back into 0..NUM_CH-1.
    assign v_raw = lfsr_q[CW-1:0];
    assign v_ext = {1'b0, v_raw};
    assign v_new = (v_ext >= (CW+1)'(NUM_CH)) ? CW'(v_ext - (CW+1)'(NUM_CH)) : v_raw;

    assign cur_sym   = seq_q[idx_q];
    assign last_elem = (LW'(idx_q) == level_q - 1'b1);
    assign press     = |bus.btn;

    always_comb begin
        cur_onehot          = '0;
        cur_onehot[cur_sym] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        seq_we  = 1'b0;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    // After a win the next round starts a fresh game.
                    if (win_q) begin
                        win_d   = 1'b0;
                        level_d = '0;
                    end
                    state_d = S_APPEND;
                end
            end
            S_APPEND: begin
                seq_we  = 1'b1;
                level_d = level_q + 1'b1;
                idx_d   = '0;
                cnt_d   = STEP_LOAD;
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (cnt_q == '0) begin
                    cnt_d   = STEP_LOAD;
                    state_d = S_SHOW_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHOW_OFF: begin
                if (cnt_q == '0) begin
                    if (last_elem) begin
                        idx_d   = '0;
                        cnt_d   = TO_LOAD;
                        state_d = S_WAIT_IN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = STEP_LOAD;
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_IN: begin
                // A press is evaluated before the timeout so a press on the
                // expiring cycle still counts.
                if (press) begin
                    if (bus.btn == cur_onehot) begin
                        if (last_elem) begin
                            state_d = S_PASS;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            cnt_d = TO_LOAD;
                        end
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q == '0) begin
                        state_d = S_FAIL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_PASS: begin
                if (level_q == LW'(MAX_LEN)) begin
                    win_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_FAIL: begin
                level_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq_q[IW'(level_q)] <= v_new;
        end
    end

    assign bus.led   = (state_q == S_SHOW_ON) ? cur_onehot : '0;
    assign bus.level = level_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.pass  = (state_q == S_PASS);
    assign bus.fail  = (state_q == S_FAIL);
    assign bus.win   = win_q;
endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer with a small configuration:
// four channels, three-element game, four-cycle light phases and a
// twenty-cycle response timeout.
module tb_memory_sequencer;
    localparam int          NUM_CH  = 4;
    localparam int          MAX_LEN = 3;
    localparam int          STEP    = 4;
    localparam int          TMO     = 20;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    memory_sequencer_if #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN)) bus ();

    memory_sequencer #(
        .NUM_CH(NUM_CH),
        .MAX_LEN(MAX_LEN),
        .STEP_CYCLES(STEP),
        .TIMEOUT_CYCLES(TMO),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus.slave)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, free running from reset.
    logic [15:0] tb_lfsr;
    always @(posedge clk) begin
        if (!resetn) tb_lfsr <= SEED;
        else         tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    int n_assert = 0;
    int n_fail   = 0;
    int exp_seq [MAX_LEN];
    int exp_level = 0;
    bit exp_win   = 1'b0;

    function automatic logic [3:0] oh(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        bus.btn = v;
        tick();
        bus.btn = '0;
    endtask

    // Start a round and check the full playback; returns in the first
    // WAIT_IN cycle. With junk set, button noise is driven during playback.
    task automatic start_round(input bit junk);
        if (exp_win) begin
            exp_level = 0;
            exp_win   = 1'b0;
        end
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        exp_seq[exp_level] = int'(tb_lfsr[1:0]);
        exp_level++;
        chk("append_busy", bus.busy, 1);
        chk("append_win", bus.win, 0);
        chk("append_led", bus.led, 0);
        tick();
        chk("show_level", bus.level, exp_level);
        for (int i = 0; i < exp_level; i++) begin
            for (int c = 0; c < STEP; c++) begin
                chk("show_on_led", bus.led, oh(exp_seq[i]));
                chk("show_on_fail", bus.fail, 0);
                if (junk) bus.btn = 4'b0011;
                tick();
                bus.btn = '0;
            end
            for (int c = 0; c < STEP; c++) begin
                chk("show_off_led", bus.led, 0);
                chk("show_off_fail", bus.fail, 0);
                if (junk) bus.btn = 4'b1000;
                tick();
                bus.btn = '0;
            end
        end
        chk("wait_led", bus.led, 0);
        chk("wait_busy", bus.busy, 1);
        chk("wait_fail", bus.fail, 0);
    endtask

    // Answer the whole sequence correctly and check the pass pulse.
    task automatic answer_all();
        for (int i = 0; i < exp_level - 1; i++) begin
            press(oh(exp_seq[i]));
            chk("mid_pass", bus.pass, 0);
            chk("mid_fail", bus.fail, 0);
            chk("mid_busy", bus.busy, 1);
        end
        press(oh(exp_seq[exp_level-1]));
        chk("final_pass", bus.pass, 1);
        chk("final_fail", bus.fail, 0);
        tick();
        if (exp_level == MAX_LEN) exp_win = 1'b1;
        chk("post_pass_pulse", bus.pass, 0);
        chk("post_pass_busy", bus.busy, 0);
        chk("post_pass_level", bus.level, exp_level);
        chk("post_pass_win", bus.win, exp_win);
    endtask

    initial begin
        resetn  = 1'b0;
        bus.go  = 1'b0;
        bus.btn = '0;
        tick();
        tick();
        chk("rst_led", bus.led, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_fail", bus.fail, 0);
        chk("rst_win", bus.win, 0);
        resetn = 1'b1;

        // Round 1 answered correctly, then a few idle cycles.
        start_round(1'b0);
        chk("r1_level", bus.level, 1);
        answer_all();
        repeat (3) begin
            tick();
            chk("idle_busy", bus.busy, 0);
            chk("idle_level", bus.level, 1);
        end

        // Round 2 replays element 0; second press wrong.
        start_round(1'b0);
        press(oh(exp_seq[0]));
        chk("r2_first_fail", bus.fail, 0);
        chk("r2_first_pass", bus.pass, 0);
        press(oh((exp_seq[1] + 1) % NUM_CH));
        chk("wrong_fail", bus.fail, 1);
        chk("wrong_pass", bus.pass, 0);
        tick();
        chk("wrong_fail_pulse", bus.fail, 0);
        chk("wrong_level", bus.level, 0);
        chk("wrong_busy", bus.busy, 0);
        chk("wrong_win", bus.win, 0);
        exp_level = 0;

        // Timeout with no presses: 20 quiet cycles, fail on the 21st.
        start_round(1'b0);
        for (int k = 2; k <= TMO; k++) begin
            tick();
            chk("tmo_quiet_fail", bus.fail, 0);
        end
        tick();
        chk("tmo_fail", bus.fail, 1);
        tick();
        chk("tmo_level", bus.level, 0);
        chk("tmo_busy", bus.busy, 0);
        exp_level = 0;

        // Correct press at cycle 19 restarts the timeout.
        start_round(1'b0);
        answer_all();
        tick();
        start_round(1'b0);
        repeat (18) tick();
        press(oh(exp_seq[0]));
        chk("restart_fail0", bus.fail, 0);
        for (int k = 0; k < TMO - 1; k++) begin
            tick();
            chk("restart_quiet_fail", bus.fail, 0);
        end
        tick();
        chk("restart_tmo_fail", bus.fail, 1);
        tick();
        chk("restart_level", bus.level, 0);
        exp_level = 0;

        // Winning game; round 1 press lands on the expiring timeout cycle.
        start_round(1'b0);
        repeat (TMO - 1) tick();
        press(oh(exp_seq[0]));
        chk("press_beats_tmo_pass", bus.pass, 1);
        chk("press_beats_tmo_fail", bus.fail, 0);
        tick();
        chk("pbt_busy", bus.busy, 0);
        start_round(1'b1);
        answer_all();
        tick();
        start_round(1'b0);
        answer_all();
        repeat (3) begin
            tick();
            chk("win_hold", bus.win, 1);
            chk("win_level", bus.level, MAX_LEN);
            chk("win_busy", bus.busy, 0);
        end

        // Next go clears win and restarts at level 1; multi-hot press fails.
        start_round(1'b0);
        chk("newgame_level", bus.level, 1);
        press(4'b0011);
        chk("multihot_fail", bus.fail, 1);
        tick();
        chk("multihot_level", bus.level, 0);
        exp_level = 0;

        // Reset in the middle of SHOW_ON.
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        resetn = 1'b0;
        tick();
        chk("midrst_led", bus.led, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_level", bus.level, 0);
        chk("midrst_fail", bus.fail, 0);
        resetn = 1'b1;
        tick();
        chk("post_rst_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_sequencer.md
# memory_sequencer

Parametrised challenge/response engine for the memory game: it grows a pseudo-random sequence by one element per round, plays it back on `NUM_CH` one-hot lights, then checks the player's button presses against it. It replaces the fixed 16-bit shift-register playback/check datapath and its controller. It sits between the board inputs (`go` switch, debounced buttons) and the LED and HEX display logic.

## Interface
- `NUM_CH`, default 4: number of lights/buttons, 2..16; `CW = $clog2(NUM_CH)`.
- `MAX_LEN`, default 16: longest sequence; reaching it and passing wins the game; `LW = $clog2(MAX_LEN+1)`.
- `STEP_CYCLES`, default 25000000: clk cycles per playback light-on phase and per light-off phase; minimum 2.
- `TIMEOUT_CYCLES`, default 250000000: maximum clk cycles between consecutive presses in the response phase; 0 disables the timeout.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  synchronous, active-low reset.
- `go`  in  1  level; starts the next round when sampled high in IDLE.
- `btn`  in  NUM_CH  player presses; single-cycle, pre-debounced pulses.
- `led`  out  NUM_CH  playback display, one-hot or zero.
- `level`  out  LW  current sequence length.
- `busy`  out  1  high in every state except IDLE.
- `pass`  out  1  one-cycle pulse when a round is answered correctly.
- `fail`  out  1  one-cycle pulse on a wrong press, a multi-hot press, or a timeout.
- `win`  out  1  sticky; set after passing round MAX_LEN.

## Operation
- LFSR: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1. It advances every clk cycle from reset, so the player's timing seeds the randomness.
- New element: `v = lfsr[CW-1:0]`. If `v >= NUM_CH`, use `v - NUM_CH`.
- Sequence store: MAX_LEN x CW registers. Contents are not cleared by reset.
- State machine:
  - IDLE: `led=0`, `busy=0`. If `go`=1 and `win`=1, clear `win` and `level` in the same cycle, then go to APPEND. If `go`=1 otherwise, go to APPEND.
  - APPEND (1 cycle): `seq[level] <= v`; `level <= level+1`; `idx <= 0`. Go to SHOW_ON.
  - SHOW_ON: `led = onehot(seq[idx])` for STEP_CYCLES cycles, then go to SHOW_OFF.
  - SHOW_OFF: `led=0` for STEP_CYCLES cycles. If `idx == level-1`, set `idx <= 0` and go to WAIT_IN. Otherwise `idx++` and go to SHOW_ON.
  - WAIT_IN: `led=0`. A nonzero `btn` is a press.
    - Press equal to `onehot(seq[idx])`: if `idx == level-1`, go to PASS; otherwise `idx++` and restart the timeout counter.
    - Any other nonzero `btn` (wrong channel or multi-hot): go to FAIL.
    - Timeout counter reaching TIMEOUT_CYCLES with no press: go to FAIL.
  - PASS (1 cycle): `pass=1`. If `level == MAX_LEN`, set `win <= 1`. Go to IDLE.
  - FAIL (1 cycle): `fail=1`; `level <= 0`. Go to IDLE.
- `btn` is ignored in every state except WAIT_IN.
- Holding `go` high auto-advances rounds: IDLE lasts one cycle.
- `level` never exceeds MAX_LEN. APPEND is entered only with `level < MAX_LEN`, because reaching MAX_LEN forces `win`.

## Timing
- Reset (resetn=0 at a clk edge): next cycle has state IDLE, `led=0`, `level=0`, `busy=0`, `pass=0`, `fail=0`, `win=0`, `lfsr=SEED`, counters 0.
- Reset mid-round abandons the round at that same edge. No `fail` pulse is produced.
- `go` sampled high in IDLE at edge N:
  - APPEND in cycle N+1.
  - SHOW_ON from N+2, with `led` valid from N+2 and `level` updated at N+2.
- `led` and all status outputs are registered or decoded from registered state only. There is no combinational path from `btn` or `go` to any output.
- Playback of a round at level L takes exactly 2·L·STEP_CYCLES cycles from the first SHOW_ON cycle to the first WAIT_IN cycle.
- A press at edge M:
  - Correct final press: `pass` high in cycle M+1, `busy=0` from M+2.
  - Wrong press: `fail` high in cycle M+1.
- Timeout: `fail` asserts in the cycle after the TIMEOUT_CYCLES-th consecutive press-free WAIT_IN cycle.
- A press and a timeout expiring in the same cycle: the press wins.

## Test plan
Bench parameters: NUM_CH=4, MAX_LEN=3, STEP_CYCLES=4, TIMEOUT_CYCLES=20.
- Reset, then `go` high for 1 cycle:
  - `led` one-hot for 4 cycles starting 2 cycles after `go`, then 0 for 4 cycles.
  - `level=1`; `busy=1` and held while waiting for input.
- Press the matching `btn` → `pass` pulse 1 cycle, then `busy=0`, `level=1`. `go` again → first element replayed unchanged, followed by a new element; `level=2`.
- Level 2: first press correct, second press wrong → `fail` pulse, `level=0`, `busy=0`, `win=0`.
- Enter WAIT_IN and press nothing for 20 cycles → `fail` pulse on the following cycle.
  - Repeat with a correct press at cycle 19 → no `fail`; the timeout counter restarts.
- Three correct rounds → `pass` on round 3 and `win=1`. `win` holds through idle cycles. Next `go` → `win=0`, `level=1`.
- `btn` pulses during SHOW_ON/SHOW_OFF → ignored, no `fail`.
- `btn=4'b0011` in WAIT_IN → `fail`.
- `resetn=0` mid-SHOW_ON → `led=0`, `busy=0`, `level=0` on the next cycle.
